// File: rtl/sipo_load_controller.sv
// Serial-in frame sequencer for a SIPO shift register: bit handshake in, word handshake out.
// Optional LOAD idle timeout is enabled with `define SIPO_CTRL_TIMEOUT_EN.
module sipo_load_controller #(
  parameter int SIZE    = 256,
  parameter int CNT_W   = $clog2(SIZE + 1),
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic             bit_ready,
  output logic             shift,
  output logic             s_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             busy,
  output logic [CNT_W-1:0] bit_count,
  output logic             timeout_err
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    HOLD
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(SIZE - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_load;
  logic             xfer;
  logic             tmo_hit;

  assign in_load    = (state_q == LOAD);
  // abort suppresses acceptance so the in-flight bit never reaches the SIPO
  assign bit_ready  = in_load & ~abort;
  assign xfer       = bit_ready & bit_valid;
  assign shift      = xfer;
  assign s_out      = bit_in;
  assign word_valid = (state_q == HOLD);
  assign busy       = (state_q != IDLE);
  assign bit_count  = cnt_q;

`ifdef SIPO_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tmo_q, tmo_d;

  assign tmo_hit     = in_load & ~abort & ~xfer
                     & (tmo_q == TW'(TIMEOUT - 1));
  assign timeout_err = tmo_hit;

  always_comb begin
    tmo_d = '0;
    if (in_load && !abort && !xfer && !tmo_hit)
      tmo_d = tmo_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = LOAD;
            cnt_d   = '0;
          end
        end
        LOAD: begin
          if (xfer) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) state_d = HOLD;
          end else if (tmo_hit) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        HOLD: begin
          if (word_ready) begin
            state_d = start ? LOAD : IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_sipo_load_controller.sv
// Directed bench for sipo_load_controller with a behavioural 256-bit SIPO.
// Build with SIPO_CTRL_TIMEOUT_EN to exercise the timeout (TIMEOUT=16 here).
module tb_sipo_load_controller;

  localparam int SIZE = 256;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic       bit_valid;
  logic       bit_in;
  logic       bit_ready;
  logic       shift;
  logic       s_out;
  logic       word_valid;
  logic       word_ready;
  logic       busy;
  logic [8:0] bit_count;
  logic       timeout_err;

  logic [SIZE-1:0] sipo;
  logic [SIZE-1:0] pat;
  logic [SIZE-1:0] pat2;
  logic [SIZE-1:0] snap;
  int              nshift;
  int              npass = 0;
  int              ntot = 0;

  sipo_load_controller #(
    .SIZE   (SIZE),
    .TIMEOUT(16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .bit_valid  (bit_valid),
    .bit_in     (bit_in),
    .bit_ready  (bit_ready),
    .shift      (shift),
    .s_out      (s_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .busy       (busy),
    .bit_count  (bit_count),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // MSB-first behavioural SIPO
  always @(posedge clk) begin
    if (shift) begin
      sipo   <= {sipo[SIZE-2:0], s_out};
      nshift <= nshift + 1;
    end
  end

  task automatic chk(input string tag,
                     input logic [SIZE-1:0] got,
                     input logic [SIZE-1:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [SIZE-1:0] w, output int bad);
    bad = 0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      bit_valid = 1'b1;
      bit_in    = w[i];
      #1;
      if (shift !== 1'b1 || word_valid !== 1'b0) bad++;
      cyc();
    end
    bit_valid = 1'b0;
  endtask

  int bad;
  int pulses;
  int pulse_at;

  initial begin
    pat  = 256'h1578_9abc_def0_2468_ace1_3579_bdf0_1122_3344_5566_7788_99aa_bbcc_ddee_ff00_55ad;
    pat2 = ~pat;
    sipo = '0;
    nshift = 0;
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    bit_valid = 1'b0;
    bit_in = 1'b0;
    word_ready = 1'b0;
    cyc();
    cyc();
    chk("rst_busy", busy, 0);
    chk("rst_cnt", bit_count, 0);
    chk("rst_ready", bit_ready, 0);
    chk("rst_wvalid", word_valid, 0);
    reset = 1'b0;
    cyc();
    chk("idle_busy", busy, 0);

    // frame 1
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("load_busy", busy, 1);
    chk("load_ready", bit_ready, 1);
    chk("load_cnt0", bit_count, 0);
    nshift = 0;
    send_word(pat, bad);
    chk("f1_stream", bad, 0);
    chk("f1_wvalid", word_valid, 1);
    chk("f1_nshift", nshift, 256);
    chk("f1_word", sipo, pat);
    chk("f1_cnt", bit_count, 256);
    chk("f1_ready", bit_ready, 0);

    // hold with traffic, start alone ignored
    snap = sipo;
    bad = 0;
    bit_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      start = (i >= 5);
      #1;
      if (word_valid !== 1'b1 || shift !== 1'b0 || bit_count !== 9'd256) bad++;
      cyc();
    end
    bit_valid = 1'b0;
    chk("hold_stable", bad, 0);
    chk("hold_word", sipo, snap);
    word_ready = 1'b1;
    start = 1'b1;
    cyc();
    word_ready = 1'b0;
    start = 1'b0;
    chk("b2b_busy", busy, 1);
    chk("b2b_wvalid", word_valid, 0);
    chk("b2b_cnt", bit_count, 0);
    chk("b2b_ready", bit_ready, 1);

    // async reset mid-frame at bit_count=100
    for (int i = 0; i < 100; i++) begin
      bit_valid = 1'b1;
      bit_in = pat[i];
      cyc();
    end
    bit_valid = 1'b0;
    chk("mid_cnt", bit_count, 100);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_cnt", bit_count, 0);
    chk("arst_shift", shift, 0);
    chk("arst_ready", bit_ready, 0);
    chk("arst_wvalid", word_valid, 0);
    cyc();
    reset = 1'b0;
    cyc();

    // toggled valid, abort at bit_count=37
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 0; k < 74; k++) begin
      bit_valid = (k % 2 == 0);
      bit_in = k[1];
      cyc();
    end
    chk("tog_cnt", bit_count, 37);
    bit_valid = 1'b1;
    abort = 1'b1;
    #1;
    chk("abort_shift", shift, 0);
    chk("abort_ready", bit_ready, 0);
    cyc();
    abort = 1'b0;
    bit_valid = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_cnt", bit_count, 0);

    start = 1'b1;
    cyc();
    start = 1'b0;
    send_word(pat2, bad);
    chk("f2_stream", bad, 0);
    chk("f2_word", sipo, pat2);
    chk("f2_wvalid", word_valid, 1);
    word_ready = 1'b1;
    cyc();
    word_ready = 1'b0;
    chk("drain_busy", busy, 0);
    chk("drain_cnt", bit_count, 0);

    // idle LOAD: timeout behaviour
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bit_valid = 1'b1;
      bit_in = 1'b1;
      cyc();
    end
    bit_valid = 1'b0;
    pulses = 0;
    pulse_at = 0;
    for (int j = 1; j <= 24; j++) begin
      #1;
      if (timeout_err === 1'b1) begin
        pulses++;
        pulse_at = j;
      end
      cyc();
    end
`ifdef SIPO_CTRL_TIMEOUT_EN
    chk("tmo_pulses", pulses, 1);
    chk("tmo_at", pulse_at, 16);
    chk("tmo_busy", busy, 0);
    chk("tmo_cnt", bit_count, 0);
`else
    chk("tmo_pulses", pulses, 0);
    chk("tmo_busy", busy, 1);
    chk("tmo_cnt", bit_count, 5);
`endif

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
